// File: rtl/itch_pkg.sv
// Shared ITCH definitions: field widths, the Add Order (no MPID) body layout and encoder states.
package itch_pkg;

    localparam int TIME_STAMP_W          = 32;
    localparam int ORDER_ID_W            = 64;
    localparam int ORDER_BOOK_ID_W       = 32;
    localparam int SIDE_W                = 8;
    localparam int ORDER_BOOK_POSITION_W = 32;
    localparam int QUANTITY_W            = 64;
    localparam int PRICE_W               = 32;
    localparam int ORDER_ATTRIBUTES_W    = 16;
    localparam int LOT_TYPE_W            = 8;

    localparam int ADD_ORDER_NO_MPID_BYTES = 36;
    localparam int ADD_ORDER_NO_MPID_BITS  = ADD_ORDER_NO_MPID_BYTES * 8;

    // Packed structs place the first member at the MSB, so the wire order is listed last-to-first.
    typedef struct packed {
        logic [LOT_TYPE_W-1:0]            lotType;
        logic [ORDER_ATTRIBUTES_W-1:0]    orderAttributes;
        logic [PRICE_W-1:0]               price;
        logic [QUANTITY_W-1:0]            quantity;
        logic [ORDER_BOOK_POSITION_W-1:0] orderBookPosition;
        logic [SIDE_W-1:0]                side;
        logic [ORDER_BOOK_ID_W-1:0]       orderBookId;
        logic [ORDER_ID_W-1:0]            orderId;
        logic [TIME_STAMP_W-1:0]          timeStamp;
    } add_order_no_mpid_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FLUSH
    } encState_t;

    function automatic logic [ADD_ORDER_NO_MPID_BITS-1:0] packAddOrderNoMpid(input add_order_no_mpid_t msg);
        return msg;
    endfunction

endpackage

// File: rtl/add_order_no_mpid_encoder.sv
// Serialises one Add Order (no MPID) body onto a densely packed 64-bit little-endian word stream.
module add_order_no_mpid_encoder
    import itch_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             ready,
    input  logic [TIME_STAMP_W-1:0]          time_stamp,
    input  logic [ORDER_ID_W-1:0]            order_id,
    input  logic [ORDER_BOOK_ID_W-1:0]       order_book_id,
    input  logic [SIDE_W-1:0]                side,
    input  logic [ORDER_BOOK_POSITION_W-1:0] order_book_position,
    input  logic [QUANTITY_W-1:0]            quantity,
    input  logic [PRICE_W-1:0]               price,
    input  logic [ORDER_ATTRIBUTES_W-1:0]    order_attributes,
    input  logic [LOT_TYPE_W-1:0]            lot_type,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [63:0]                      out_data,
    output logic [7:0]                       out_keep,
    output logic [5:0]                       tracker_out
);

    encState_t          state;
    logic [319:0]       shiftBuf;
    logic [55:0]        residue;
    logic [2:0]         rCount;
    logic [2:0]         pendingCount;
    logic [2:0]         wordIdx;
    logic [2:0]         lastIdx;

    add_order_no_mpid_t msgFields;
    logic [ADD_ORDER_NO_MPID_BITS-1:0] msgVec;
    logic [319:0]       acceptBuf;
    logic [5:0]         byteSum;
    logic               handshake;

    assign msgFields = '{
        lotType:           lot_type,
        orderAttributes:   order_attributes,
        price:             price,
        quantity:          quantity,
        orderBookPosition: order_book_position,
        side:              side,
        orderBookId:       order_book_id,
        orderId:           order_id,
        timeStamp:         time_stamp
    };
    assign msgVec = packAddOrderNoMpid(msgFields);

    // New message bytes land directly after the residue bytes already held.
    assign acceptBuf = ({32'b0, msgVec} << {rCount, 3'b000}) | {264'b0, residue};
    assign byteSum   = {3'b000, rCount} + 6'd36;
    assign handshake = out_valid && out_ready;

    assign tracker_out = {rCount, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shiftBuf     <= '0;
            residue      <= '0;
            rCount       <= '0;
            pendingCount <= '0;
            wordIdx      <= '0;
            lastIdx      <= '0;
            ready        <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_keep     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shiftBuf     <= acceptBuf;
                        out_data     <= acceptBuf[63:0];
                        out_keep     <= 8'hFF;
                        out_valid    <= 1'b1;
                        ready        <= 1'b0;
                        wordIdx      <= '0;
                        lastIdx      <= byteSum[5:3] - 3'd1;
                        pendingCount <= byteSum[2:0];
                        state        <= SEND;
                    end else if (flush && rCount != 3'd0) begin
                        out_data  <= {8'b0, residue};
                        out_keep  <= (8'd1 << rCount) - 8'd1;
                        out_valid <= 1'b1;
                        ready     <= 1'b0;
                        state     <= FLUSH;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (wordIdx == lastIdx) begin
                            // Whatever sits above the final full word becomes the new residue.
                            residue   <= shiftBuf[119:64];
                            rCount    <= pendingCount;
                            shiftBuf  <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_keep  <= '0;
                            ready     <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            shiftBuf <= shiftBuf >> 64;
                            out_data <= shiftBuf[127:64];
                            wordIdx  <= wordIdx + 3'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (handshake) begin
                        residue   <= '0;
                        rCount    <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_keep  <= '0;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ready     <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_order_no_mpid_encoder.sv
// Self-checking bench for add_order_no_mpid_encoder using a byte-queue reference model.
module tb_add_order_no_mpid_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [31:0] time_stamp;
    logic [63:0] order_id;
    logic [31:0] order_book_id;
    logic [7:0]  side;
    logic [31:0] order_book_position;
    logic [63:0] quantity;
    logic [31:0] price;
    logic [15:0] order_attributes;
    logic [7:0]  lot_type;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic [5:0]  tracker_out;

    int checkCount = 0;
    int passCount  = 0;

    // Reference stream: bytes accepted but not yet sent, oldest first.
    byte unsigned refQ[$];

    always #5 clk = ~clk;

    add_order_no_mpid_encoder dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .ready               (ready),
        .time_stamp          (time_stamp),
        .order_id            (order_id),
        .order_book_id       (order_book_id),
        .side                (side),
        .order_book_position (order_book_position),
        .quantity            (quantity),
        .price               (price),
        .order_attributes    (order_attributes),
        .lot_type            (lot_type),
        .flush               (flush),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_keep            (out_keep),
        .tracker_out         (tracker_out)
    );

    task automatic setFixedFields();
        time_stamp          = 32'h11223344;
        order_id            = 64'h0102030405060708;
        order_book_id       = 32'hAABBCCDD;
        side                = 8'h42;
        order_book_position = 32'h00000005;
        quantity            = 64'h1000;
        price               = 32'h00989680;
        order_attributes    = 16'h0001;
        lot_type            = 8'h01;
    endtask

    task automatic setRandomFields();
        time_stamp          = $urandom;
        order_id            = {$urandom, $urandom};
        order_book_id       = $urandom;
        side                = 8'($urandom);
        order_book_position = $urandom;
        quantity            = {$urandom, $urandom};
        price               = $urandom;
        order_attributes    = 16'($urandom);
        lot_type            = 8'($urandom);
    endtask

    // Each field is little-endian; fields follow one another in wire order.
    task automatic modelPushMessage();
        logic [287:0] v;
        v = {lot_type, order_attributes, price, quantity, order_book_position,
             side, order_book_id, order_id, time_stamp};
        for (int i = 0; i < 36; i++) refQ.push_back(v[8*i +: 8]);
    endtask

    task automatic modelPopWord(output logic [63:0] w);
        w = '0;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = refQ.pop_front();
    endtask

    task automatic modelFlushWord(output logic [63:0] w, output logic [7:0] k);
        int n;
        n = refQ.size();
        w = '0;
        k = '0;
        for (int b = 0; b < n; b++) begin
            w[8*b +: 8] = refQ.pop_front();
            k[b] = 1'b1;
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        setFixedFields();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        refQ.delete();
    endtask

    task automatic sendMsg(input bit withFlush);
        start = 1'b1;
        flush = withFlush;
        modelPushMessage();
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        setRandomFields();
    endtask

    // Waits (bounded) for the next handshaked word; returns with ok=0 on timeout.
    task automatic getWord(input bit randomReady, output logic [63:0] d, output logic [7:0] k, output bit ok);
        ok = 1'b0;
        d = '0;
        k = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                d = out_data;
                k = out_keep;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        @(negedge clk);
        checkCount++;
        if ({ready, out_valid, out_data, out_keep, tracker_out} !== {1'b1, 1'b0, 64'h0, 8'h0, 6'd0})
            $display("[TB] FAIL reset_state: ready=%b valid=%b data=%h keep=%h tracker=%0d, expected 1 0 0 0 0",
                     ready, out_valid, out_data, out_keep, tracker_out);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [63:0] expWords [4];
        logic [63:0] d, m;
        logic [7:0]  k;
        bit ok;
        expWords = '{64'h0506070811223344, 64'hAABBCCDD01020304, 64'h0010000000000542, 64'h9896800000000000};
        setFixedFields();
        sendMsg(1'b0);
        for (int i = 0; i < 4; i++) begin
            getWord(1'b0, d, k, ok);
            modelPopWord(m);
            checkCount++;
            if (!ok || d !== expWords[i] || d !== m || k !== 8'hFF)
                $display("[TB] FAIL single_w%0d: got %h keep %h ok=%b, expected %h keep ff", i, d, k, ok, expWords[i]);
            else passCount++;
        end
        @(negedge clk);
        checkCount++;
        if (tracker_out !== 6'd32 || ready !== 1'b1)
            $display("[TB] FAIL single_tracker: tracker=%0d ready=%b, expected 32 1", tracker_out, ready);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [63:0] d, m;
        logic [7:0]  k, mk;
        bit ok;
        bit seen;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        getWord(1'b0, d, k, ok);
        modelFlushWord(m, mk);
        checkCount++;
        if (!ok || d !== 64'h0000000001000100 || k !== 8'h0F || d !== m || k !== mk)
            $display("[TB] FAIL flush_word: got %h keep %h ok=%b, expected 0000000001000100 keep 0f", d, k, ok);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (tracker_out !== 6'd0) $display("[TB] FAIL flush_tracker: got %0d, expected 0", tracker_out);
        else passCount++;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkCount++;
        if (seen || ready !== 1'b1) $display("[TB] FAIL flush_empty: out_valid seen=%b ready=%b, expected 0 1", seen, ready);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] d, m;
        logic [7:0]  k;
        bit ok;
        applyReset();
        for (int msg = 0; msg < 2; msg++) begin
            setFixedFields();
            sendMsg(1'b0);
            for (int i = 0; i < 4 + msg; i++) begin
                getWord(1'b0, d, k, ok);
                modelPopWord(m);
                checkCount++;
                if (!ok || d !== m || k !== 8'hFF || (msg == 1 && i == 0 && d !== 64'h1122334401000100))
                    $display("[TB] FAIL b2b_m%0d_w%0d: got %h keep %h ok=%b, expected %h keep ff", msg, i, d, k, ok, m);
                else passCount++;
            end
        end
        @(negedge clk);
        checkCount++;
        if (tracker_out !== 6'd0 || refQ.size() != 0)
            $display("[TB] FAIL b2b_tracker: got %0d, expected 0 (model residue %0d)", tracker_out, refQ.size());
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [63:0] d, m;
        logic [7:0]  k;
        bit ok;
        applyReset();
        setFixedFields();
        sendMsg(1'b0);
        getWord(1'b0, d, k, ok);
        modelPopWord(m);
        checkCount++;
        if (!ok || d !== m) $display("[TB] FAIL bp_w0: got %h ok=%b, expected %h", d, ok, m);
        else passCount++;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++;
            if (out_valid !== 1'b1 || out_data !== 64'hAABBCCDD01020304 || out_keep !== 8'hFF)
                $display("[TB] FAIL bp_hold%0d: valid=%b data=%h keep=%h, expected 1 aabbccdd01020304 ff",
                         i, out_valid, out_data, out_keep);
            else passCount++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            getWord(1'b0, d, k, ok);
            modelPopWord(m);
            checkCount++;
            if (!ok || d !== m || k !== 8'hFF) $display("[TB] FAIL bp_w%0d: got %h keep %h ok=%b, expected %h", i, d, k, ok, m);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d, m;
        logic [7:0]  k;
        bit ok;
        applyReset();
        setFixedFields();
        sendMsg(1'b0);
        for (int i = 0; i < 2; i++) getWord(1'b0, d, k, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        refQ.delete();
        @(negedge clk);
        checkCount++;
        if (out_valid !== 1'b0 || ready !== 1'b1 || tracker_out !== 6'd0)
            $display("[TB] FAIL midrst_state: valid=%b ready=%b tracker=%0d, expected 0 1 0", out_valid, ready, tracker_out);
        else passCount++;
        @(posedge clk); #1;
        setFixedFields();
        sendMsg(1'b0);
        getWord(1'b0, d, k, ok);
        modelPopWord(m);
        checkCount++;
        if (!ok || d !== 64'h0506070811223344 || d !== m)
            $display("[TB] FAIL midrst_w0: got %h ok=%b, expected 0506070811223344", d, ok);
        else passCount++;
        for (int i = 1; i < 4; i++) begin
            getWord(1'b0, d, k, ok);
            modelPopWord(m);
        end
        refQ.delete();
    endtask

    task automatic test_start_flush();
        logic [63:0] d, m;
        logic [7:0]  k;
        bit ok;
        bit seen;
        applyReset();
        setFixedFields();
        sendMsg(1'b0);
        for (int i = 0; i < 4; i++) begin
            getWord(1'b0, d, k, ok);
            modelPopWord(m);
        end
        setRandomFields();
        sendMsg(1'b1);
        for (int i = 0; i < 5; i++) begin
            getWord(1'b0, d, k, ok);
            modelPopWord(m);
            checkCount++;
            if (!ok || d !== m || k !== 8'hFF)
                $display("[TB] FAIL startflush_w%0d: got %h keep %h ok=%b, expected %h keep ff", i, d, k, ok, m);
            else passCount++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkCount++;
        if (seen || tracker_out !== 6'd0)
            $display("[TB] FAIL startflush_noop: valid seen=%b tracker=%0d, expected 0 0", seen, tracker_out);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [63:0] d, m;
        logic [7:0]  k, mk;
        bit ok;
        int nWords;
        applyReset();
        for (int msg = 0; msg < 20; msg++) begin
            setRandomFields();
            sendMsg(1'b0);
            nWords = refQ.size() / 8;
            for (int i = 0; i < nWords; i++) begin
                getWord(1'b1, d, k, ok);
                modelPopWord(m);
                checkCount++;
                if (!ok || d !== m || k !== 8'hFF)
                    $display("[TB] FAIL rand_m%0d_w%0d: got %h keep %h ok=%b, expected %h", msg, i, d, k, ok, m);
                else passCount++;
            end
            @(negedge clk);
            checkCount++;
            if (tracker_out !== 6'(8 * refQ.size()))
                $display("[TB] FAIL rand_m%0d_tracker: got %0d, expected %0d", msg, tracker_out, 8 * refQ.size());
            else passCount++;
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0 && refQ.size() != 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                getWord(1'b1, d, k, ok);
                modelFlushWord(m, mk);
                checkCount++;
                if (!ok || d !== m || k !== mk)
                    $display("[TB] FAIL rand_m%0d_flush: got %h keep %h ok=%b, expected %h keep %h", msg, d, k, ok, m, mk);
                else passCount++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flush();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_start_flush();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
